// File: rtl/regfile_param.sv
// Parametrised register file: DEPTH x WIDTH storage, one synchronous write port,
// NUM_RD combinational read ports, optional hardwired-zero word 0 and write-to-read bypass.
module regfile_param #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned NUM_RD    = 2,
    parameter bit          ZERO_REG0 = 1'b1,
    parameter bit          BYPASS    = 1'b1
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      we,
    input  logic [AW-1:0]             wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [NUM_RD*AW-1:0]      rd_addr,
    output logic [NUM_RD*WIDTH-1:0]   rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;

    // A write is legal only in range and, with a hardwired zero word, never to address 0.
    assign wr_ok = we && (32'(wr_addr) < DEPTH) && !(ZERO_REG0 && (wr_addr == '0));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                mem[j] <= '0;
            end
        end else if (wr_ok) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (wr_addr == AW'(j)) begin
                    mem[j] <= wr_data;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] word;

        assign addr = rd_addr[i*AW +: AW];

        // Out-of-range addresses fall through every compare and read 0.
        always_comb begin
            word = '0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (addr == AW'(j)) begin
                    word = mem[j];
                end
            end
            if (BYPASS && wr_ok && (addr == wr_addr)) begin
                word = wr_data;
            end
            if ((ZERO_REG0 && (addr == '0)) || clr) begin
                word = '0;
            end
        end

        assign rd_data[i*WIDTH +: WIDTH] = word;
    end

endmodule
